// File: rtl/rs_station_pkg.sv
// Shared definitions for the reservation station: default sizes, id/data types
// and the 4-bit ALU / branch-compare op codes.
package rs_station_pkg;

  localparam int RS_ENTRY_NUM = 8;
  localparam int ROB_ID_W     = 4;
  localparam int REG_W        = 32;

  typedef logic [$clog2(RS_ENTRY_NUM)-1:0] rs_id_t;
  typedef logic [ROB_ID_W-1:0]             ro_buffer_id_t;
  typedef logic [REG_W-1:0]                reg_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11,
    OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15
  } rs_op_e;

endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU / branch comparator. Compare ops return 1 or 0;
// shift amounts come from vk[4:0].
module rs_alu
  import rs_station_pkg::*;
#(
  parameter int W = REG_W
) (
  input  rs_op_e       op,
  input  logic [W-1:0] vj,
  input  logic [W-1:0] vk,
  output logic [W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = vk[4:0];

  always_comb begin
    // NOTE: every path assigns result, so no latch is inferred.
    result = '0;
    unique case (op)
      OP_ADD:  result = vj + vk;
      OP_SUB:  result = vj - vk;
      OP_AND:  result = vj & vk;
      OP_OR:   result = vj | vk;
      OP_XOR:  result = vj ^ vk;
      OP_SLL:  result = vj << shamt;
      OP_SRL:  result = vj >> shamt;
      OP_SRA:  result = $signed(vj) >>> shamt;
      OP_SLT:  result = W'($signed(vj) < $signed(vk));
      OP_SLTU: result = W'(vj < vk);
      OP_BEQ:  result = W'(vj == vk);
      OP_BNE:  result = W'(vj != vk);
      OP_BLT:  result = W'($signed(vj) < $signed(vk));
      OP_BGE:  result = W'($signed(vj) >= $signed(vk));
      OP_BLTU: result = W'(vj < vk);
      OP_BGEU: result = W'(vj >= vk);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds issued ALU/branch ops until both operands are
// tagged ready, snoops the two result buses, and dispatches one op per cycle.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int ENTRY_NUM    = RS_ENTRY_NUM,
  parameter int ROB_ID_WIDTH = ROB_ID_W,
  parameter int REG_WIDTH    = REG_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    issue_valid_in,
  input  logic [3:0]              issue_op_in,
  input  logic [ROB_ID_WIDTH-1:0] issue_qj_in,
  input  logic [REG_WIDTH-1:0]    issue_vj_in,
  input  logic [ROB_ID_WIDTH-1:0] issue_qk_in,
  input  logic [REG_WIDTH-1:0]    issue_vk_in,
  input  logic [ROB_ID_WIDTH-1:0] issue_dest_in,
  input  logic [REG_WIDTH-1:0]    issue_pc_in,
  output logic                    full_out,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rss_bus,
  input  logic [REG_WIDTH-1:0]    value_from_rss_bus,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_lsb_bus,
  input  logic [REG_WIDTH-1:0]    value_from_lsb_bus,
  output logic [ROB_ID_WIDTH-1:0] dest_to_rss_bus,
  output logic [REG_WIDTH-1:0]    value_to_rss_bus,
  output logic [REG_WIDTH-1:0]    pc_to_rss_bus
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]    busy;
  rs_op_e                  op_q   [ENTRY_NUM];
  logic [ROB_ID_WIDTH-1:0] qj_q   [ENTRY_NUM];
  logic [ROB_ID_WIDTH-1:0] qk_q   [ENTRY_NUM];
  logic [REG_WIDTH-1:0]    vj_q   [ENTRY_NUM];
  logic [REG_WIDTH-1:0]    vk_q   [ENTRY_NUM];
  logic [ROB_ID_WIDTH-1:0] dest_q [ENTRY_NUM];
  logic [REG_WIDTH-1:0]    pc_q   [ENTRY_NUM];

  logic [IDX_W-1:0]        free_idx, sel_idx;
  logic                    sel_found;
  logic [ROB_ID_WIDTH-1:0] new_qj, new_qk;
  logic [REG_WIDTH-1:0]    new_vj, new_vk;
  logic [REG_WIDTH-1:0]    alu_result;

  function automatic logic tag_hit(input logic [ROB_ID_WIDTH-1:0] q,
                                   input logic [ROB_ID_WIDTH-1:0] tag);
    return (q != '0) && (q == tag);
  endfunction

  assign full_out = &busy;

  // Lowest-index free slot and lowest-index ready slot.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (busy[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Issue-time bypass; the load bus wins if both buses carry the tag.
  always_comb begin
    new_qj = issue_qj_in;
    new_vj = issue_vj_in;
    new_qk = issue_qk_in;
    new_vk = issue_vk_in;
    if (tag_hit(issue_qj_in, dest_from_lsb_bus)) begin
      new_qj = '0;
      new_vj = value_from_lsb_bus;
    end else if (tag_hit(issue_qj_in, dest_from_rss_bus)) begin
      new_qj = '0;
      new_vj = value_from_rss_bus;
    end
    if (tag_hit(issue_qk_in, dest_from_lsb_bus)) begin
      new_qk = '0;
      new_vk = value_from_lsb_bus;
    end else if (tag_hit(issue_qk_in, dest_from_rss_bus)) begin
      new_qk = '0;
      new_vk = value_from_rss_bus;
    end
  end

  rs_alu #(.W(REG_WIDTH)) u_alu (
    .op     (op_q[sel_idx]),
    .vj     (vj_q[sel_idx]),
    .vk     (vk_q[sel_idx]),
    .result (alu_result)
  );

  always_ff @(posedge clk_in) begin
    // NOTE: only busy bits are reset; payload fields are don't-care while
    // their entry is free, so the storage array needs no reset.
    if (!rst_in) begin
      busy             <= '0;
      dest_to_rss_bus  <= '0;
      value_to_rss_bus <= '0;
      pc_to_rss_bus    <= '0;
    end else if (flush_in) begin
      busy            <= '0;
      dest_to_rss_bus <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (busy[i]) begin
          if (tag_hit(qj_q[i], dest_from_lsb_bus)) begin
            qj_q[i] <= '0;
            vj_q[i] <= value_from_lsb_bus;
          end else if (tag_hit(qj_q[i], dest_from_rss_bus)) begin
            qj_q[i] <= '0;
            vj_q[i] <= value_from_rss_bus;
          end
          if (tag_hit(qk_q[i], dest_from_lsb_bus)) begin
            qk_q[i] <= '0;
            vk_q[i] <= value_from_lsb_bus;
          end else if (tag_hit(qk_q[i], dest_from_rss_bus)) begin
            qk_q[i] <= '0;
            vk_q[i] <= value_from_rss_bus;
          end
        end
      end

      if (sel_found) begin
        busy[sel_idx]    <= 1'b0;
        dest_to_rss_bus  <= dest_q[sel_idx];
        value_to_rss_bus <= alu_result;
        pc_to_rss_bus    <= pc_q[sel_idx];
      end else begin
        dest_to_rss_bus <= '0;
      end

      // The free slot is never the dispatched one, so these writes don't collide.
      if (issue_valid_in && !full_out) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= rs_op_e'(issue_op_in);
        qj_q[free_idx]   <= new_qj;
        vj_q[free_idx]   <= new_vj;
        qk_q[free_idx]   <= new_qk;
        vk_q[free_idx]   <= new_vk;
        dest_q[free_idx] <= issue_dest_in;
        pc_q[free_idx]   <= issue_pc_in;
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural station model.
module tb_rs_station;

  localparam int N = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, issue_valid_in;
  logic [3:0]  issue_op_in, issue_qj_in, issue_qk_in, issue_dest_in;
  logic [31:0] issue_vj_in, issue_vk_in, issue_pc_in;
  logic        full_out;
  logic [3:0]  dest_from_rss_bus, dest_from_lsb_bus, dest_to_rss_bus;
  logic [31:0] value_from_rss_bus, value_from_lsb_bus;
  logic [31:0] value_to_rss_bus, pc_to_rss_bus;

  rs_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_op_in(issue_op_in),
    .issue_qj_in(issue_qj_in), .issue_vj_in(issue_vj_in),
    .issue_qk_in(issue_qk_in), .issue_vk_in(issue_vk_in),
    .issue_dest_in(issue_dest_in), .issue_pc_in(issue_pc_in),
    .full_out(full_out),
    .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
    .dest_from_lsb_bus(dest_from_lsb_bus), .value_from_lsb_bus(value_from_lsb_bus),
    .dest_to_rss_bus(dest_to_rss_bus), .value_to_rss_bus(value_to_rss_bus),
    .pc_to_rss_bus(pc_to_rss_bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          busy;
    int          op;
    logic [3:0]  qj, qk, dest;
    logic [31:0] vj, vk, pc;
  } entry_t;

  entry_t      m [N];
  logic [3:0]  e_dest;
  logic [31:0] e_val, e_pc;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return $signed(a) >>> sh;
      8, 12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9, 14: return (a < b) ? 32'd1 : 32'd0;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      13: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Operand wakeup from the buses as seen this cycle; load bus has priority.
  function automatic void wake(input logic [3:0] q, input logic [31:0] v,
                               output logic [3:0] qo, output logic [31:0] vo);
    qo = q;
    vo = v;
    if (q != 0 && q == dest_from_lsb_bus) begin
      qo = 0; vo = value_from_lsb_bus;
    end else if (q != 0 && q == dest_from_rss_bus) begin
      qo = 0; vo = value_from_rss_bus;
    end
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Advance one clock: predict the next state from the present inputs, then compare.
  task automatic step();
    entry_t      n [N];
    logic [3:0]  nd;
    logic [31:0] nv, np;
    int          sel, fr;
    n = m; nd = e_dest; nv = e_val; np = e_pc;
    if (!rst_in) begin
      for (int i = 0; i < N; i++) n[i].busy = 0;
      nd = 0; nv = 0; np = 0;
    end else if (flush_in) begin
      for (int i = 0; i < N; i++) n[i].busy = 0;
      nd = 0;
    end else begin
      sel = -1;
      fr  = -1;
      for (int i = 0; i < N; i++) begin
        if (sel < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) sel = i;
        if (fr < 0 && !m[i].busy) fr = i;
        if (m[i].busy) begin
          wake(m[i].qj, m[i].vj, n[i].qj, n[i].vj);
          wake(m[i].qk, m[i].vk, n[i].qk, n[i].vk);
        end
      end
      if (sel >= 0) begin
        nd = m[sel].dest;
        nv = ref_alu(m[sel].op, m[sel].vj, m[sel].vk);
        np = m[sel].pc;
        n[sel].busy = 0;
      end else begin
        nd = 0;
      end
      if (issue_valid_in && fr >= 0) begin
        n[fr].busy = 1;
        n[fr].op   = int'(issue_op_in);
        n[fr].dest = issue_dest_in;
        n[fr].pc   = issue_pc_in;
        wake(issue_qj_in, issue_vj_in, n[fr].qj, n[fr].vj);
        wake(issue_qk_in, issue_vk_in, n[fr].qk, n[fr].vk);
      end
    end
    @(posedge clk_in);
    #1;
    m = n; e_dest = nd; e_val = nv; e_pc = np;
    check("dest", 32'(dest_to_rss_bus), 32'(e_dest));
    check("value", value_to_rss_bus, e_val);
    check("pc", pc_to_rss_bus, e_pc);
    check("full", 32'(full_out), 32'(model_full()));
  endtask

  task automatic idle_inputs();
    flush_in = 0; issue_valid_in = 0; issue_op_in = 0;
    issue_qj_in = 0; issue_vj_in = 0; issue_qk_in = 0; issue_vk_in = 0;
    issue_dest_in = 0; issue_pc_in = 0;
    dest_from_rss_bus = 0; value_from_rss_bus = 0;
    dest_from_lsb_bus = 0; value_from_lsb_bus = 0;
  endtask

  task automatic set_issue(input int op, input int qj, input logic [31:0] vj,
                           input int qk, input logic [31:0] vk, input int dest,
                           input logic [31:0] pc);
    issue_valid_in = 1; issue_op_in = 4'(op);
    issue_qj_in = 4'(qj); issue_vj_in = vj;
    issue_qk_in = 4'(qk); issue_vk_in = vk;
    issue_dest_in = 4'(dest); issue_pc_in = pc;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i] = '{busy: 0, op: 0, qj: 0, qk: 0, dest: 0, vj: 0, vk: 0, pc: 0};
    e_dest = 0; e_val = 0; e_pc = 0;
    idle_inputs();
    rst_in = 0;

    // Reset then idle
    step(); step();
    rst_in = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_dest", 32'(dest_to_rss_bus), 32'd0);
      check("idle_full", 32'(full_out), 32'd0);
    end

    // Ready issue: result two cycles after issue, for exactly one cycle
    set_issue(0, 0, 32'd5, 0, 32'd7, 3, 32'h100);
    step();
    idle_inputs();
    step();
    check("rdy_dest", 32'(dest_to_rss_bus), 32'd3);
    check("rdy_value", value_to_rss_bus, 32'd12);
    check("rdy_pc", pc_to_rss_bus, 32'h100);
    step();
    check("rdy_done", 32'(dest_to_rss_bus), 32'd0);

    // Snoop wakeup from the load bus
    set_issue(1, 2, 32'd0, 0, 32'd1, 4, 32'h104);
    step();
    idle_inputs();
    step(); step();
    dest_from_lsb_bus = 4'd2; value_from_lsb_bus = 32'd10;
    step();
    idle_inputs();
    step();
    check("snoop_dest", 32'(dest_to_rss_bus), 32'd4);
    check("snoop_value", value_to_rss_bus, 32'd9);

    // Issue-time bypass from the rss bus
    set_issue(9, 6, 32'd0, 0, 32'd1, 5, 32'h108);
    dest_from_rss_bus = 4'd6; value_from_rss_bus = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    step();
    check("byp_dest", 32'(dest_to_rss_bus), 32'd5);
    check("byp_value", value_to_rss_bus, 32'd0);

    // Full, ignored 9th issue, then flush
    for (int i = 0; i < N; i++) begin
      set_issue(0, 9, 32'd0, 0, 32'(i), i + 1, 32'h200 + 32'(4 * i));
      step();
    end
    check("full_set", 32'(full_out), 32'd1);
    set_issue(0, 0, 32'd1, 0, 32'd1, 15, 32'h300);
    step();
    check("full_hold", 32'(full_out), 32'd1);
    idle_inputs();
    step();
    check("full_no9th", 32'(dest_to_rss_bus), 32'd0);
    flush_in = 1;
    step();
    idle_inputs();
    check("flush_full", 32'(full_out), 32'd0);
    dest_from_rss_bus = 4'd9; value_from_rss_bus = 32'd77;
    step();
    idle_inputs();
    step();
    check("flush_gone", 32'(dest_to_rss_bus), 32'd0);
    step();
    check("flush_gone2", 32'(dest_to_rss_bus), 32'd0);

    // Ordering and signed compare: entries 1 and 5 wake together
    set_issue(0, 10, 0, 0, 0, 1, 32'h400); step();
    set_issue(12, 11, 0, 0, 32'd1, 2, 32'h404); step();
    for (int i = 2; i < 5; i++) begin
      set_issue(0, 10, 0, 0, 0, i + 1, 32'h400 + 32'(4 * i)); step();
    end
    set_issue(4, 0, 32'd0, 11, 0, 6, 32'h414); step();
    idle_inputs();
    dest_from_rss_bus = 4'd11; value_from_rss_bus = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    step();
    check("ord_first", 32'(dest_to_rss_bus), 32'd2);
    check("ord_blt", value_to_rss_bus, 32'd1);
    step();
    check("ord_second", 32'(dest_to_rss_bus), 32'd6);
    check("ord_xor", value_to_rss_bus, 32'hFFFF_FFFF);
    flush_in = 1;
    step();
    idle_inputs();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_in         = ($urandom_range(0, 399) != 0);
      flush_in       = ($urandom_range(0, 59) == 0);
      issue_valid_in = ($urandom_range(0, 99) < 55);
      issue_op_in    = 4'($urandom_range(0, 15));
      issue_qj_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      issue_qk_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      issue_vj_in    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      issue_vk_in    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      issue_dest_in  = 4'($urandom_range(1, 15));
      issue_pc_in    = $urandom;
      dest_from_rss_bus  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      value_from_rss_bus = $urandom;
      dest_from_lsb_bus  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      value_from_lsb_bus = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
